// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder
//   Registered WIDTH-bit adder built from a two-level carry-lookahead tree:
//   GROUP-bit blocks produce group propagate/generate, a top-level unit
//   derives each group's carry-in from cin, and sum bits are p ^ carry.
//   The result is captured in an output register (1-cycle latency).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears Sum, cout, out_valid)
//   in_valid   operands valid; result register loads when high
//   A, B       operands, [0:WIDTH-1], index 0 = MSB
//   cin        carry into the LSB (index WIDTH-1)
//   Sum        registered sum, [0:WIDTH-1], index 0 = MSB
//   cout       registered carry out of the MSB
//   out_valid  Sum/cout hold a result from an in_valid cycle
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [0:WIDTH-1] A,
  input  logic [0:WIDTH-1] B,
  input  logic             cin,
  output logic [0:WIDTH-1] Sum,
  output logic             cout,
  output logic             out_valid
);

  localparam int NG = WIDTH / GROUP;

  // Little-endian internal copies: vector assignment is positional, so
  // a_le[WIDTH-1] is A[0] (the MSB) and a_le[0] is the LSB.
  logic [WIDTH-1:0] a_le;
  logic [WIDTH-1:0] b_le;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] c;      // carry into each bit
  logic [WIDTH-1:0] s;
  logic [NG-1:0]    gp;
  logic [NG-1:0]    gg;
  logic [NG:0]      gc;     // carry into each group; gc[NG] is cout

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  assign a_le = A;
  assign b_le = B;

  always_comb begin
    p = a_le ^ b_le;
    g = a_le & b_le;
  end

  // Group propagate/generate, scanned from the group's LSB upward.
  always_comb begin
    gp = '1;
    gg = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      for (int unsigned i = 0; i < GROUP; i++) begin
        gg[k] = g[k*GROUP+i] | (p[k*GROUP+i] & gg[k]);
        gp[k] = gp[k] & p[k*GROUP+i];
      end
    end
  end

  // Top-level lookahead: each group carry is the flattened sum of products
  // G[j] & P[j+1..k] plus cin & P[0..k], so no group waits on its neighbour.
  always_comb begin
    logic prod;
    logic chain;
    gc    = '0;
    gc[0] = cin;
    for (int unsigned k = 0; k < NG; k++) begin
      chain = cin;
      for (int unsigned m = 0; m <= k; m++) chain = chain & gp[m];
      for (int unsigned j = 0; j <= k; j++) begin
        prod = gg[j];
        for (int unsigned m = j + 1; m <= k; m++) prod = prod & gp[m];
        chain = chain | prod;
      end
      gc[k+1] = chain;
    end
  end

  // In-group lookahead from the group carry, same flattened form per bit.
  always_comb begin
    logic prod;
    logic chain;
    c = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      for (int unsigned i = 0; i < GROUP; i++) begin
        chain = gc[k];
        for (int unsigned m = 0; m < i; m++) chain = chain & p[k*GROUP+m];
        for (int unsigned j = 0; j < i; j++) begin
          prod = g[k*GROUP+j];
          for (int unsigned m = j + 1; m < i; m++) prod = prod & p[k*GROUP+m];
          chain = chain | prod;
        end
        c[k*GROUP+i] = chain;
      end
    end
    s = p ^ c;
  end

  always_comb begin
    sum_d       = sum_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      sum_d  = s;
      cout_d = gc[NG];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Sum       = sum_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
module tb_pipelined_cla_adder;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [0:W-1] a;
  logic [0:W-1] b;
  logic         cin;
  logic [0:W-1] sum;
  logic         cout;
  logic         out_valid;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  exp_t exp_q[$];
  int   compared   = 0;
  int   mismatched = 0;

  pipelined_cla_adder #(.WIDTH(W), .GROUP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .cin       (cin),
    .Sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one operand set at the falling edge and record its expected result.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic vc, input logic [W-1:0] es, input logic ec);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    a        = va;
    b        = vb;
    cin      = vc;
    e.sum    = es;
    e.cout   = ec;
    exp_q.push_back(e);
  endtask

  // After the next rising edge, pop the oldest expectation and compare.
  task automatic collect(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 64'd0, 64'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_sum"},   64'(sum),       64'(e.sum));
      check({tag, "_cout"},  64'(cout),      64'(e.cout));
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
    end
  endtask

  task automatic issue_model(input string tag);
    logic [W-1:0] ra, rb;
    logic         rc;
    logic [W:0]   tot;
    ra  = $urandom;
    rb  = $urandom;
    rc  = 1'($urandom_range(0, 1));
    tot = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
    issue(ra, rb, rc, tot[W-1:0], tot[W]);
    collect(tag);
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;

    // Reset state, then idle after release.
    @(posedge clk);
    #1;
    check("rst_sum",   64'(sum),       64'd0);
    check("rst_cout",  64'(cout),      64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_sum",   64'(sum),       64'd0);
    check("idle_cout",  64'(cout),      64'd0);
    check("idle_valid", 64'(out_valid), 64'd0);

    // Directed vectors on consecutive cycles.
    issue(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0); collect("z0");
    issue(32'h00000000, 32'h0000F000, 1'b0, 32'h0000F000, 1'b0); collect("z1");
    issue(32'h0000F000, 32'h00000000, 1'b0, 32'h0000F000, 1'b0); collect("z2");
    issue(32'h0000F000, 32'h0000F000, 1'b0, 32'h0001E000, 1'b0); collect("z3");
    issue(32'hFFFFFFFE, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0); collect("nf0");
    issue(32'hFFFFFFFD, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b0); collect("nf1");
    issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1); collect("wr0");
    issue(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1); collect("wr1");
    issue(32'hFFFFFFFE, 32'h00000001, 1'b1, 32'h00000000, 1'b1); collect("wr2");

    // Drop in_valid: result holds, out_valid clears.
    @(negedge clk);
    in_valid = 1'b0;
    a        = 32'h12345678;
    b        = 32'h9ABCDEF0;
    @(posedge clk);
    #1;
    check("hold_sum",   64'(sum),       64'd0);
    check("hold_cout",  64'(cout),      64'd1);
    check("hold_valid", 64'(out_valid), 64'd0);

    // Carry rippling through alternating groups, then random traffic.
    issue(32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 32'h00000000, 1'b1); collect("alt0");
    issue(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0); collect("msb0");
    issue(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1); collect("msb1");
    for (int i = 0; i < 8; i++) issue_model($sformatf("rnd%0d", i));

    // Async reset between edges while out_valid is high.
    #2;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    check("arst_sum",   64'(sum),       64'd0);
    check("arst_cout",  64'(cout),      64'd0);
    check("arst_valid", 64'(out_valid), 64'd0);

    // in_valid high while reset is held: nothing is captured.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 32'hFFFFFFFF;
    b        = 32'hFFFFFFFF;
    cin      = 1'b1;
    @(posedge clk);
    #1;
    check("rstwin_sum",   64'(sum),       64'd0);
    check("rstwin_cout",  64'(cout),      64'd0);
    check("rstwin_valid", 64'(out_valid), 64'd0);

    // First load after release.
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back('{sum: 32'hFFFFFFFF, cout: 1'b1});
    collect("post_rst");
    @(negedge clk);
    in_valid = 1'b0;
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Registered WIDTH-bit binary adder with carry-in and carry-out.
- Internally a two-level carry-lookahead structure: GROUP-bit lookahead blocks, with group propagate/generate feeding a top-level carry unit.
- Used as the integer add datapath element; its output register isolates downstream timing.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of GROUP, range 4..64.
- GROUP, 4, carry-lookahead group size in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid this cycle; the result register loads when high.
- A  in  WIDTH  operand A; declared [0:WIDTH-1], index 0 = MSB.
- B  in  WIDTH  operand B; same bit ordering as A.
- cin  in  1  carry into the LSB (index WIDTH-1).
- Sum  out  WIDTH  registered sum; declared [0:WIDTH-1], index 0 = MSB.
- cout  out  1  registered carry out of the MSB.
- out_valid  out  1  Sum/cout hold a result produced by an in_valid cycle.

Behaviour:
- Reset: rst_n low asynchronously forces Sum=0, cout=0, out_valid=0, independent of clk. Registers stay cleared while rst_n is low. The first load can occur at the first rising edge after rst_n goes high.
- Arithmetic: {cout, Sum} = A + B + cin, computed as unsigned WIDTH+1-bit values. Sum = (A+B+cin) mod 2^WIDTH; cout = 1 iff A+B+cin >= 2^WIDTH.
  - No overflow flag; signed overflow is out of scope.
- Bit ordering: carries propagate from index WIDTH-1 (LSB) toward index 0 (MSB). Hex values are written MSB-first.
- Latency: 1 cycle. On a rising edge with in_valid=1, the Sum/cout registers load the combinational result of the current A/B/cin, and out_valid is set to 1.
- On a rising edge with in_valid=0: Sum/cout hold their previous values and out_valid is cleared to 0.
- Throughput: one addition per cycle; back-to-back in_valid cycles each produce a result on the following cycle.
- No backpressure; the consumer must take the result in the cycle out_valid is high.
- Carry structure:
  - Per bit: p = a XOR b, g = a AND b.
  - Per group: group P/G computed from the bit p/g values.
  - Top level: group carries computed by lookahead from cin and the group P/G values; cout is the carry out of the most-significant group.
  - Within a group: sum bit = p XOR incoming carry.
- Boundary cases:
  - All-ones + 1 wraps to 0 with cout=1.
  - cin=1 with an all-ones operand and zero other operand wraps likewise.
  - Carry propagates across all group boundaries within one cycle.
- Reset asserted in the same cycle as in_valid: reset wins, and no result is captured.

Test Plan:
- Reset then idle: rst_n=0 -> Sum=0, cout=0, out_valid=0; after release with in_valid=0, values stay 0.
- Zero and single-operand adds (WIDTH=32, cin=0):
  - 0+0 -> Sum=00000000, cout=0.
  - 0+0000F000 -> 0000F000.
  - 0000F000+0 -> 0000F000.
  - 0000F000+0000F000 -> 0001E000, cout=0.
  - Each result appears one cycle after in_valid, with out_valid=1.
- Near-full without carry:
  - FFFFFFFE+00000001, cin=0 -> FFFFFFFF, cout=0.
  - FFFFFFFD+00000001, cin=1 -> FFFFFFFF, cout=0.
- Full wrap:
  - FFFFFFFF+00000001, cin=0 -> 00000000, cout=1.
  - FFFFFFFF+00000000, cin=1 -> 00000000, cout=1.
  - FFFFFFFE+00000001, cin=1 -> 00000000, cout=1.
- Back-to-back and hold:
  - Issue the nine vectors above on consecutive cycles -> each result appears on the next cycle.
  - Then drop in_valid -> Sum/cout hold the last result (00000000, 1) and out_valid goes to 0.
- Async reset mid-stream: assert rst_n low between clock edges while out_valid=1 -> outputs clear immediately, without waiting for a clock edge.
